// File: rtl/jk_register_bank_if.sv
// Bus bundle for jk_register_bank: control/data inputs and state/status outputs.
interface jk_register_bank_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             stat_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_not;
    logic [WIDTH-1:0] changed;
    logic [CNT_W-1:0] chg_cnt;
    logic             sr_err;

    modport master (
        output en, mode, a, b, load, load_val, stat_clr,
        input  q, q_not, changed, chg_cnt, sr_err
    );

    modport slave (
        input  en, mode, a, b, load, load_val, stat_clr,
        output q, q_not, changed, chg_cnt, sr_err
    );
endinterface

// File: rtl/jk_register_bank.sv
// Multi-mode (JK/T/D/SR) flip-flop bank with parallel load, clock enable,
// per-bit change flags, saturating change counter and sticky SR-conflict flag.
module jk_register_bank #(
    parameter int               WIDTH     = 4,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    jk_register_bank_if.slave bus
);
    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] changed;
    logic [CNT_W-1:0] chg_cnt;
    logic             sr_err;
    logic             sr_conflict;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end
        return value + 1'b1;
    endfunction

    // Next-state selection: load beats enabled mode update, otherwise hold.
    always_comb begin
        q_next      = q;
        sr_conflict = 1'b0;
        if (bus.load) begin
            q_next = bus.load_val;
        end else if (bus.en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case (bus.mode)
                    MODE_JK: begin
                        case ({bus.a[i], bus.b[i]})
                            2'b01:   q_next[i] = 1'b0;
                            2'b10:   q_next[i] = 1'b1;
                            2'b11:   q_next[i] = ~q[i];
                            default: q_next[i] = q[i];
                        endcase
                    end
                    MODE_T:  q_next[i] = bus.a[i] ? ~q[i] : q[i];
                    MODE_D:  q_next[i] = bus.a[i];
                    default: begin
                        case ({bus.a[i], bus.b[i]})
                            2'b01:   q_next[i] = 1'b0;
                            2'b10:   q_next[i] = 1'b1;
                            default: q_next[i] = q[i];
                        endcase
                    end
                endcase
            end
            sr_conflict = (bus.mode == MODE_SR) && (|(bus.a & bus.b));
        end
    end

    // State, change flags and status registers; clear beats same-edge increment/set.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RESET_VAL;
            changed <= '0;
            chg_cnt <= '0;
            sr_err  <= 1'b0;
        end else begin
            q       <= q_next;
            changed <= q_next ^ q;
            if (bus.stat_clr) begin
                chg_cnt <= '0;
                sr_err  <= 1'b0;
            end else begin
                if (q_next != q) begin
                    chg_cnt <= sat_inc(chg_cnt);
                end
                if (sr_conflict) begin
                    sr_err <= 1'b1;
                end
            end
        end
    end

    assign bus.q       = q;
    assign bus.q_not   = ~q;
    assign bus.changed = changed;
    assign bus.chg_cnt = chg_cnt;
    assign bus.sr_err  = sr_err;
endmodule

// File: tb/tb_jk_register_bank.sv
// Scoreboard bench for jk_register_bank: directed scenarios plus random traffic.
module tb_jk_register_bank;
    localparam int               WIDTH     = 4;
    localparam int               CNT_W     = 3;
    localparam logic [WIDTH-1:0] RESET_VAL = 4'b0000;
    localparam int               CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] changed;
        logic [CNT_W-1:0] cnt;
        logic             err;
        string            tag;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    logic done;

    int checks;
    int errors;

    // Reference model state
    logic [WIDTH-1:0] m_q;
    int               m_cnt;
    logic             m_err;

    jk_register_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    jk_register_bank #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VAL(RESET_VAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at negedge and push the model's prediction.
    task automatic cyc(input logic r, input logic ld, input logic [3:0] lv,
                       input logic e, input logic [1:0] md, input logic [3:0] av,
                       input logic [3:0] bv, input logic sc, input string tag);
        logic [WIDTH-1:0] nq;
        logic             conflict;
        exp_t             x;
        @(negedge clk);
        rst = r; bus.load = ld; bus.load_val = lv; bus.en = e;
        bus.mode = md; bus.a = av; bus.b = bv; bus.stat_clr = sc;
        conflict = 1'b0;
        if (r) begin
            m_q = RESET_VAL; m_cnt = 0; m_err = 1'b0;
            x.changed = '0;
        end else begin
            nq = m_q;
            if (ld) nq = lv;
            else if (e) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (md == 2'd0) begin        // JK
                        if (av[i] && bv[i]) nq[i] = !m_q[i];
                        else if (av[i])     nq[i] = 1'b1;
                        else if (bv[i])     nq[i] = 1'b0;
                    end else if (md == 2'd1) begin // T
                        if (av[i]) nq[i] = !m_q[i];
                    end else if (md == 2'd2) begin // D
                        nq[i] = av[i];
                    end else begin               // SR
                        if (av[i] && bv[i])  conflict = 1'b1;
                        else if (av[i])      nq[i] = 1'b1;
                        else if (bv[i])      nq[i] = 1'b0;
                    end
                end
            end
            x.changed = nq ^ m_q;
            if (sc) begin
                m_cnt = 0; m_err = 1'b0;
            end else begin
                if (nq != m_q && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                if (conflict) m_err = 1'b1;
            end
            m_q = nq;
        end
        x.q = m_q; x.cnt = CNT_W'(m_cnt); x.err = m_err; x.tag = tag;
        exp_q.push_back(x);
    endtask

    // Monitor: after each edge, pop one prediction and compare every output.
    initial begin
        exp_t x;
        checks = 0;
        errors = 0;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover_queue got %0d entries required 0", exp_q.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                checks++;
                if (bus.q !== x.q) begin
                    errors++; $display("FAIL %s q got %b required %b", x.tag, bus.q, x.q);
                end
                checks++;
                if (bus.q_not !== ~x.q) begin
                    errors++; $display("FAIL %s q_not got %b required %b", x.tag, bus.q_not, ~x.q);
                end
                checks++;
                if (bus.changed !== x.changed) begin
                    errors++; $display("FAIL %s changed got %b required %b", x.tag, bus.changed, x.changed);
                end
                checks++;
                if (bus.chg_cnt !== x.cnt) begin
                    errors++; $display("FAIL %s chg_cnt got %0d required %0d", x.tag, bus.chg_cnt, x.cnt);
                end
                checks++;
                if (bus.sr_err !== x.err) begin
                    errors++; $display("FAIL %s sr_err got %b required %b", x.tag, bus.sr_err, x.err);
                end
            end
        end
    end

    // Stimulus: spec scenarios first, then randomized traffic.
    initial begin
        done = 1'b0;
        rst = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.en = 1'b0;
        bus.mode = 2'd0; bus.a = '0; bus.b = '0; bus.stat_clr = 1'b0;
        m_q = RESET_VAL; m_cnt = 0; m_err = 1'b0;

        // 1. reset, then idle
        cyc(1, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 0, "reset");
        cyc(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 0, "idle_after_reset");
        // 2. JK toggle/set/clear/hold from 0110
        cyc(0, 1, 4'b0110, 0, 2'd0, 4'h0, 4'h0, 0, "load_0110");
        cyc(0, 0, 4'h0, 1, 2'd0, 4'b1100, 4'b1010, 0, "jk_mix");
        // 3. T toggles, counter saturates at 7
        cyc(0, 0, 4'h0, 0, 2'd1, 4'h0, 4'h0, 1, "clear_before_t");
        for (int i = 0; i < 9; i++)
            cyc(0, 0, 4'h0, 1, 2'd1, 4'b1111, 4'h0, 0, "t_toggle");
        // 4. SR with conflict, then clear
        cyc(0, 1, 4'b0000, 0, 2'd3, 4'h0, 4'h0, 0, "load_0000");
        cyc(0, 0, 4'h0, 1, 2'd3, 4'b0011, 4'b0101, 0, "sr_conflict");
        cyc(0, 0, 4'h0, 0, 2'd3, 4'h0, 4'h0, 1, "stat_clr");
        // 5. load wins over enabled D, then hold
        cyc(0, 1, 4'b1001, 1, 2'd2, 4'b0110, 4'h0, 0, "load_wins");
        cyc(0, 0, 4'h0, 0, 2'd2, 4'b0110, 4'h0, 0, "hold_after_load");
        // 6. reset overrides load and stat_clr at 1111
        cyc(0, 1, 4'b1111, 0, 2'd0, 4'h0, 4'h0, 0, "load_1111");
        cyc(1, 1, 4'b0101, 1, 2'd1, 4'b1111, 4'h0, 1, "rst_overrides");
        cyc(0, 0, 4'h0, 1, 2'd2, 4'b1010, 4'h0, 0, "first_after_reset");
        // Random traffic
        for (int n = 0; n < 300; n++) begin
            cyc(($urandom_range(49) == 0), ($urandom_range(7) == 0), 4'($urandom),
                ($urandom_range(3) != 0), 2'($urandom), 4'($urandom), 4'($urandom),
                ($urandom_range(15) == 0), "random");
        end
        @(negedge clk);
        done = 1'b1;
    end
endmodule
